// File: rtl/mem_access.sv
// Memory-access stage between EX and WB. It holds one instruction at a time and runs a
// single-outstanding byte/half/word load/store on the data port. Load data is aligned and
// extended, and the result is kept in the MEM/WB register that feeds the combinational WB stage.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  // EX side
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_PC,
  input  logic [31:0] ex_inst,
  input  logic [7:0]  ex_CTRL,
  input  logic [14:0] ex_rs,
  input  logic [31:0] ex_CAL_res,
  input  logic [31:0] ex_st_data,
  // Data-memory port
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  // MEM/WB register
  output logic        wb_valid,
  output logic [31:0] wb_PC,
  output logic [31:0] wb_inst,
  output logic [7:0]  wb_CTRL,
  output logic [14:0] wb_rs,
  output logic [31:0] wb_CAL_res,
  output logic [31:0] wb_data
);

  localparam int unsigned Word   = 32;
  localparam int unsigned RegLog = 5;
  localparam int unsigned RsW    = 3 * RegLog;

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  // Byte-lane enables for a store of the given size at byte offset a.
  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] strb;
    case (size)
      2'b00:   strb = 4'b0001 << a;
      2'b01:   strb = a[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Store data replicated across every lane the size can occupy.
  function automatic logic [Word-1:0] store_data(input logic [1:0] size, input logic [Word-1:0] d);
    logic [Word-1:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Pick the addressed byte/half out of the read word and sign- or zero-extend it.
  function automatic logic [Word-1:0] load_data(input logic [1:0]      size,
                                                input logic            uns,
                                                input logic [1:0]      a,
                                                input logic [Word-1:0] rd);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [Word-1:0] res;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   res = {{24{~uns & b[7]}}, b};
      2'b01:   res = {{16{~uns & h[15]}}, h};
      default: res = rd;
    endcase
    return res;
  endfunction

  state_e          state_q, state_d;

  // Instruction held while the memory transaction is outstanding
  logic [Word-1:0] pc_q, pc_d;
  logic [Word-1:0] inst_q, inst_d;
  logic [7:0]      ctrl_q, ctrl_d;
  logic [RsW-1:0]  rs_q, rs_d;
  logic [Word-1:0] cal_q, cal_d;

  // Registered memory request
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [Word-1:0] addr_q, addr_d;
  logic [Word-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;

  // MEM/WB register
  logic            wb_valid_q, wb_valid_d;
  logic [Word-1:0] wb_pc_q, wb_pc_d;
  logic [Word-1:0] wb_inst_q, wb_inst_d;
  logic [7:0]      wb_ctrl_q, wb_ctrl_d;
  logic [RsW-1:0]  wb_rs_q, wb_rs_d;
  logic [Word-1:0] wb_cal_q, wb_cal_d;
  logic [Word-1:0] wb_data_q, wb_data_d;

  logic            ex_is_mem;
  logic            ex_is_store;
  logic            held_is_load;

  // MEM = {mem_read, mem_write}; 11 counts as a load, so only 01 is a store.
  assign ex_is_mem    = ex_CTRL[5:4] != 2'b00;
  assign ex_is_store  = ex_CTRL[5:4] == 2'b01;
  assign held_is_load = ctrl_q[5];

  // Next-state: accept from EX, run the memory handshake, fill MEM/WB.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    ctrl_d     = ctrl_q;
    rs_d       = rs_q;
    cal_d      = cal_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    // Bubble by default: CTRL cleared so WB never writes, other fields hold.
    wb_valid_d = 1'b0;
    wb_ctrl_d  = '0;
    wb_pc_d    = wb_pc_q;
    wb_inst_d  = wb_inst_q;
    wb_rs_d    = wb_rs_q;
    wb_cal_d   = wb_cal_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      StIdle: begin
        if (ex_valid) begin
          pc_d   = ex_PC;
          inst_d = ex_inst;
          ctrl_d = ex_CTRL;
          rs_d   = ex_rs;
          cal_d  = ex_CAL_res;
          if (!ex_is_mem) begin
            wb_valid_d = 1'b1;
            wb_pc_d    = ex_PC;
            wb_inst_d  = ex_inst;
            wb_ctrl_d  = ex_CTRL;
            wb_rs_d    = ex_rs;
            wb_cal_d   = ex_CAL_res;
            wb_data_d  = '0;
          end else begin
            state_d = StReq;
            req_d   = 1'b1;
            we_d    = ex_is_store;
            addr_d  = {ex_CAL_res[31:2], 2'b00};
            if (ex_is_store) begin
              wdata_d = store_data(ex_inst[23:22], ex_st_data);
              wstrb_d = store_strb(ex_inst[23:22], ex_CAL_res[1:0]);
            end else begin
              wdata_d = '0;
              wstrb_d = '0;
            end
          end
        end
      end
      StReq: begin
        if (dmem_ack) begin
          state_d    = StIdle;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_pc_d    = pc_q;
          wb_inst_d  = inst_q;
          wb_ctrl_d  = ctrl_q;
          wb_rs_d    = rs_q;
          wb_cal_d   = cal_q;
          wb_data_d  = held_is_load ?
                       load_data(inst_q[23:22], inst_q[25], cal_q[1:0], dmem_rdata) : '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      inst_q     <= '0;
      ctrl_q     <= '0;
      rs_q       <= '0;
      cal_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_pc_q    <= '0;
      wb_inst_q  <= '0;
      wb_ctrl_q  <= '0;
      wb_rs_q    <= '0;
      wb_cal_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      ctrl_q     <= ctrl_d;
      rs_q       <= rs_d;
      cal_q      <= cal_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wb_valid_q <= wb_valid_d;
      wb_pc_q    <= wb_pc_d;
      wb_inst_q  <= wb_inst_d;
      wb_ctrl_q  <= wb_ctrl_d;
      wb_rs_q    <= wb_rs_d;
      wb_cal_q   <= wb_cal_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign ex_ready   = (state_q == StIdle);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;
  assign wb_valid   = wb_valid_q;
  assign wb_PC      = wb_pc_q;
  assign wb_inst    = wb_inst_q;
  assign wb_CTRL    = wb_ctrl_q;
  assign wb_rs      = wb_rs_q;
  assign wb_CAL_res = wb_cal_q;
  assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: a transaction-level model predicts every cycle's outputs and a
// negedge compare process checks them; directed literal checks pin the model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_PC, ex_inst, ex_CAL_res, ex_st_data;
  logic [7:0]  ex_CTRL;
  logic [14:0] ex_rs;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid;
  logic [31:0] wb_PC, wb_inst, wb_CAL_res, wb_data;
  logic [7:0]  wb_CTRL;
  logic [14:0] wb_rs;

  always #5 clk = ~clk;

  mem_access dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_PC      (ex_PC),
    .ex_inst    (ex_inst),
    .ex_CTRL    (ex_CTRL),
    .ex_rs      (ex_rs),
    .ex_CAL_res (ex_CAL_res),
    .ex_st_data (ex_st_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .wb_valid   (wb_valid),
    .wb_PC      (wb_PC),
    .wb_inst    (wb_inst),
    .wb_CTRL    (wb_CTRL),
    .wb_rs      (wb_rs),
    .wb_CAL_res (wb_CAL_res),
    .wb_data    (wb_data)
  );

  // LoongArch encodings: [23:22] size, [25] unsigned
  localparam logic [31:0] InstAdd  = 32'h0010_0c41;
  localparam logic [31:0] InstLdB  = 32'h2800_0000;
  localparam logic [31:0] InstLdH  = 32'h2840_0000;
  localparam logic [31:0] InstLdW  = 32'h2880_0000;
  localparam logic [31:0] InstStB  = 32'h2900_0000;
  localparam logic [31:0] InstStH  = 32'h2940_0000;
  localparam logic [31:0] InstStW  = 32'h2980_0000;
  localparam logic [31:0] InstLdBu = 32'h2a00_0000;
  localparam logic [31:0] InstLdHu = 32'h2a40_0000;
  localparam logic [7:0]  CtrlAdd  = 8'b10_00_0001;
  localparam logic [7:0]  CtrlLd   = 8'b11_10_0000;
  localparam logic [7:0]  CtrlSt   = 8'b00_01_0000;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int unsigned nbytes(input logic [31:0] inst);
    case (inst[23:22])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // First byte lane of the access: offset rounded down to the access size.
  function automatic int unsigned lane_lo(input logic [31:0] inst, input logic [31:0] addr);
    int unsigned nb;
    nb = nbytes(inst);
    return (int'(addr[1:0]) / nb) * nb;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] inst, input logic [31:0] addr,
                                         input logic [31:0] rd);
    int unsigned nb, lo;
    longint      v;
    nb = nbytes(inst);
    lo = lane_lo(inst, addr);
    v  = 0;
    for (int i = 0; i < int'(nb); i++)
      v += longint'((rd >> (8 * (lo + i))) & 32'hff) << (8 * i);
    if (nb < 4 && !inst[25] && v >= (longint'(1) << (8 * nb - 1)))
      v -= longint'(1) << (8 * nb);
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_strb(input logic [31:0] inst, input logic [31:0] addr);
    logic [3:0]  s;
    int unsigned lo;
    lo = lane_lo(inst, addr);
    s  = '0;
    for (int i = 0; i < 4; i++)
      if (i >= int'(lo) && i < int'(lo + nbytes(inst))) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] inst, input logic [31:0] d);
    logic [31:0] w;
    int unsigned nb;
    nb = nbytes(inst);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8 * (i % nb) +: 8];
    return w;
  endfunction

  bit          m_init = 1'b0;
  bit          m_busy;
  bit          m_wb_valid;
  bit          m_known;
  logic [31:0] p_pc, p_inst, p_cal, p_sd;
  logic [7:0]  p_ctrl;
  logic [14:0] p_rs;
  logic [31:0] m_pc, m_inst, m_cal, m_data;
  logic [7:0]  m_ctrl;
  logic [14:0] m_rs;

  // Model: one instruction in flight, result visible the cycle after accept/ack.
  always @(posedge clk) begin
    m_wb_valid <= 1'b0;
    if (rst) begin
      m_init <= 1'b1;
      m_busy <= 1'b0;
      m_pc   <= '0;
      m_inst <= '0;
      m_ctrl <= '0;
      m_rs   <= '0;
      m_cal  <= '0;
      m_data <= '0;
      m_known <= 1'b1;
    end else if (!m_busy) begin
      if (ex_valid) begin
        if (ex_CTRL[5:4] == 2'b00) begin
          m_wb_valid <= 1'b1;
          m_pc    <= ex_PC;
          m_inst  <= ex_inst;
          m_ctrl  <= ex_CTRL;
          m_rs    <= ex_rs;
          m_cal   <= ex_CAL_res;
          m_known <= 1'b0;
        end else begin
          m_busy <= 1'b1;
          p_pc   <= ex_PC;
          p_inst <= ex_inst;
          p_ctrl <= ex_CTRL;
          p_rs   <= ex_rs;
          p_cal  <= ex_CAL_res;
          p_sd   <= ex_st_data;
        end
      end
    end else if (dmem_ack) begin
      m_busy     <= 1'b0;
      m_wb_valid <= 1'b1;
      m_pc       <= p_pc;
      m_inst     <= p_inst;
      m_ctrl     <= p_ctrl;
      m_rs       <= p_rs;
      m_cal      <= p_cal;
      m_data     <= p_ctrl[5] ? m_load(p_inst, p_cal, dmem_rdata) : 32'h0;
      m_known    <= 1'b1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_init) begin
      check("ex_ready", 32'(ex_ready), 32'(!m_busy));
      check("dmem_req", 32'(dmem_req), 32'(m_busy));
      if (m_busy) begin
        check("dmem_addr", dmem_addr, {p_cal[31:2], 2'b00});
        check("dmem_we", 32'(dmem_we), 32'(p_ctrl[5:4] == 2'b01));
        if (p_ctrl[5:4] == 2'b01) begin
          check("dmem_wstrb", 32'(dmem_wstrb), 32'(m_strb(p_inst, p_cal)));
          check("dmem_wdata", dmem_wdata, m_wdata(p_inst, p_sd));
        end
      end
      check("wb_valid", 32'(wb_valid), 32'(m_wb_valid));
      check("wb_CTRL", 32'(wb_CTRL), m_wb_valid ? 32'(m_ctrl) : 32'h0);
      check("wb_PC", wb_PC, m_pc);
      check("wb_inst", wb_inst, m_inst);
      check("wb_rs", 32'(wb_rs), 32'(m_rs));
      check("wb_CAL_res", wb_CAL_res, m_cal);
      if (m_known) check("wb_data", wb_data, m_data);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] pc_next = 32'h1c00_0000;

  task automatic drive(input logic [31:0] inst, input logic [7:0] ctrl,
                       input logic [31:0] cal, input logic [31:0] sd);
    ex_valid   = 1'b1;
    ex_PC      = pc_next;
    ex_inst    = inst;
    ex_CTRL    = ctrl;
    ex_rs      = pc_next[16:2] ^ 15'h2a5;
    ex_CAL_res = cal;
    ex_st_data = sd;
    pc_next    = pc_next + 32'd4;
  endtask

  // Issue a memory op at the current negedge, ack after `waits` extra req cycles.
  // Returns at the negedge of the cycle the result sits in MEM/WB.
  task automatic mem_op(input logic [31:0] inst, input logic [7:0] ctrl,
                        input logic [31:0] cal, input logic [31:0] sd,
                        input int waits, input logic [31:0] rd,
                        output int reqc, output logic [31:0] a_seen,
                        output logic [3:0] s_seen, output logic [31:0] w_seen,
                        output logic we_seen);
    drive(inst, ctrl, cal, sd);
    @(negedge clk);
    ex_valid = 1'b0;
    a_seen   = dmem_addr;
    s_seen   = dmem_wstrb;
    w_seen   = dmem_wdata;
    we_seen  = dmem_we;
    reqc     = 0;
    repeat (waits) begin
      if (dmem_req) reqc++;
      @(negedge clk);
    end
    if (dmem_req) reqc++;
    dmem_ack   = 1'b1;
    dmem_rdata = rd;
    @(negedge clk);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'hdead_0000;
  endtask

  int          rc;
  logic [31:0] a_s, w_s;
  logic [3:0]  s_s;
  logic        we_s;

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_PC = '0; ex_inst = '0; ex_CTRL = '0; ex_rs = '0;
    ex_CAL_res = '0; ex_st_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst ex_ready", 32'(ex_ready), 32'd1);
    check("rst dmem_addr", dmem_addr, 32'h0);
    check("rst dmem_wstrb", 32'(dmem_wstrb), 32'h0);
    check("rst wb_valid", 32'(wb_valid), 32'd0);

    // Non-memory op
    drive(InstAdd, CtrlAdd, 32'h0000_1234, 32'h0);
    @(negedge clk);
    ex_valid = 1'b0;
    check("add wb_valid", 32'(wb_valid), 32'd1);
    check("add wb_CAL_res", wb_CAL_res, 32'h0000_1234);
    check("add wb_CTRL", 32'(wb_CTRL), 32'h81);
    @(negedge clk);
    check("bubble wb_CTRL", 32'(wb_CTRL), 32'h0);

    // ld.b signed, 3 wait cycles
    mem_op(InstLdB, CtrlLd, 32'h0000_1003, 32'h0, 3, 32'h80AA_BBCC, rc, a_s, s_s, w_s, we_s);
    check("ld.b dmem_addr", a_s, 32'h0000_1000);
    check("ld.b req cycles", 32'(rc), 32'd4);
    check("ld.b wb_data", wb_data, 32'hFFFF_FF80);

    // ld.hu / ld.h upper half
    mem_op(InstLdHu, CtrlLd, 32'h0000_2002, 32'h0, 0, 32'h9ABC_1234, rc, a_s, s_s, w_s, we_s);
    check("ld.hu wb_data", wb_data, 32'h0000_9ABC);
    mem_op(InstLdH, CtrlLd, 32'h0000_2002, 32'h0, 1, 32'h9ABC_1234, rc, a_s, s_s, w_s, we_s);
    check("ld.h wb_data", wb_data, 32'hFFFF_9ABC);
    mem_op(InstLdBu, CtrlLd, 32'h0000_2001, 32'h0, 0, 32'h9ABC_F234, rc, a_s, s_s, w_s, we_s);
    check("ld.bu wb_data", wb_data, 32'h0000_00F2);

    // Stores
    mem_op(InstStB, CtrlSt, 32'h0000_3001, 32'hDEAD_BE5A, 0, 32'h0, rc, a_s, s_s, w_s, we_s);
    check("st.b dmem_we", 32'(we_s), 32'd1);
    check("st.b wstrb", 32'(s_s), 32'b0010);
    check("st.b wdata", w_s, 32'h5A5A_5A5A);
    check("st.b wb_data", wb_data, 32'h0);
    mem_op(InstStH, CtrlSt, 32'h0000_3002, 32'hDEAD_BE5A, 2, 32'h0, rc, a_s, s_s, w_s, we_s);
    check("st.h wstrb", 32'(s_s), 32'b1100);
    check("st.h wdata", w_s, 32'hBE5A_BE5A);
    mem_op(InstStW, CtrlSt, 32'h0000_3007, 32'h1357_9BDF, 0, 32'h0, rc, a_s, s_s, w_s, we_s);
    check("st.w wstrb", 32'(s_s), 32'b1111);
    check("st.w addr", a_s, 32'h0000_3004);

    // Reset while a request is outstanding, then a late ack
    drive(InstStW, CtrlSt, 32'h0000_4000, 32'h1122_3344);
    @(negedge clk);
    ex_valid = 1'b0;
    check("pre-rst dmem_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dmem_ack = 1'b1;
    check("rst-mid dmem_req", 32'(dmem_req), 32'd0);
    check("rst-mid ex_ready", 32'(ex_ready), 32'd1);
    @(negedge clk);
    dmem_ack = 1'b0;
    check("late ack wb_valid", 32'(wb_valid), 32'd0);

    // Spurious ack in IDLE
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("idle ack wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);

    // Back-to-back: ld.w then add held on the bus
    drive(InstLdW, CtrlLd, 32'h0000_5006, 32'h0);
    @(negedge clk);
    drive(InstAdd, CtrlAdd, 32'h0000_0777, 32'h0);
    check("b2b ex_ready low", 32'(ex_ready), 32'd0);
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("b2b ld wb_valid", 32'(wb_valid), 32'd1);
    check("b2b ld wb_data", wb_data, 32'hCAFE_F00D);
    check("b2b ld wb_CAL_res", wb_CAL_res, 32'h0000_5006);
    check("b2b ex_ready high", 32'(ex_ready), 32'd1);
    @(negedge clk);
    ex_valid = 1'b0;
    check("b2b add wb_valid", 32'(wb_valid), 32'd1);
    check("b2b add wb_inst", wb_inst, InstAdd);
    check("b2b add wb_CAL_res", wb_CAL_res, 32'h0000_0777);
    @(negedge clk);
    check("b2b tail wb_valid", 32'(wb_valid), 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
